// File: rtl/battleship_pkg.sv
// Shared definitions for the Battleship placement logic: segment indices, FSM encoding,
// and the cell-index / cursor-move helpers.
package battleship_pkg;

  localparam logic [2:0] SEG_A = 3'd0;
  localparam logic [2:0] SEG_B = 3'd1;
  localparam logic [2:0] SEG_C = 3'd2;
  localparam logic [2:0] SEG_D = 3'd3;
  localparam logic [2:0] SEG_E = 3'd4;
  localparam logic [2:0] SEG_F = 3'd5;
  localparam logic [2:0] SEG_G = 3'd6;

  typedef enum logic [1:0] {
    ST_PLACE   = 2'd0,
    ST_CPU_GEN = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DIR_U = 2'd0,
    DIR_D = 2'd1,
    DIR_L = 2'd2,
    DIR_R = 2'd3
  } dir_e;

  localparam logic [1:0] STEP_NONE = 2'b00;
  localparam logic [1:0] STEP_INC  = 2'b01;
  localparam logic [1:0] STEP_DEC  = 2'b10;

  typedef struct packed {
    logic [2:0] seg;
    logic [1:0] step;
  } move_t;

  function automatic int unsigned cell_idx(input int unsigned digit, input logic [2:0] seg);
    return digit * 7 + {29'd0, seg};
  endfunction

  // Columns: left {f,e}, middle {a,g,d}, right {b,c}; R off the right column
  // steps to the next digit rightwards (digit-1), L off the left column to digit+1.
  function automatic move_t cursor_move(input logic [2:0] seg, input dir_e dir);
    move_t m;
    m.seg  = seg;
    m.step = STEP_NONE;
    case (dir)
      DIR_U: begin
        case (seg)
          SEG_G:   m.seg = SEG_A;
          SEG_D:   m.seg = SEG_G;
          SEG_E:   m.seg = SEG_F;
          SEG_C:   m.seg = SEG_B;
          default: ;
        endcase
      end
      DIR_D: begin
        case (seg)
          SEG_A:   m.seg = SEG_G;
          SEG_G:   m.seg = SEG_D;
          SEG_F:   m.seg = SEG_E;
          SEG_B:   m.seg = SEG_C;
          default: ;
        endcase
      end
      DIR_R: begin
        case (seg)
          SEG_F:   m.seg = SEG_A;
          SEG_E:   m.seg = SEG_D;
          SEG_A:   m.seg = SEG_B;
          SEG_G:   m.seg = SEG_B;
          SEG_D:   m.seg = SEG_C;
          SEG_B:   begin m.seg = SEG_F; m.step = STEP_DEC; end
          SEG_C:   begin m.seg = SEG_E; m.step = STEP_DEC; end
          default: ;
        endcase
      end
      DIR_L: begin
        case (seg)
          SEG_B:   m.seg = SEG_A;
          SEG_C:   m.seg = SEG_D;
          SEG_A:   m.seg = SEG_F;
          SEG_G:   m.seg = SEG_F;
          SEG_D:   m.seg = SEG_E;
          SEG_F:   begin m.seg = SEG_B; m.step = STEP_INC; end
          SEG_E:   begin m.seg = SEG_C; m.step = STEP_INC; end
          default: ;
        endcase
      end
      default: ;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ship_place_ctrl_lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16/14/13/11, used as the CPU fleet placement source.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] out
);

  logic fb;
  assign fb = out[15] ^ out[13] ^ out[12] ^ out[10];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     out <= SEED;
    else if (en) out <= {out[14:0], fb};
  end

endmodule

// File: rtl/ship_place_ctrl.sv
// Battleship ship-placement controller: cursor/toggle placement of the player fleet,
// LFSR-driven CPU fleet generation and multiplexed 7-segment display drive.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_PLACE   | player moves cursor and toggles ships; confirm at full fleet
//  ST_CPU_GEN | one LFSR candidate per clk until the CPU fleet is full
//  ST_DONE    | both fleets fixed, held until rst
module ship_place_ctrl
  import battleship_pkg::*;
#(
  parameter int          NUM_DIGITS = 4,
  parameter int          MAX_SHIPS  = 4,
  parameter int          SCAN_DIV   = 1024,
  parameter int          BLINK_DIV  = 65536,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             phase,
  input  logic                             sel,
  input  logic                             confirm,
  input  logic                             btnU,
  input  logic                             btnD,
  input  logic                             btnL,
  input  logic                             btnR,
  output logic [NUM_DIGITS-1:0]            an,
  output logic [7:0]                       seg,
  output logic [NUM_DIGITS*7-1:0]          pships,
  output logic [NUM_DIGITS*7-1:0]          cships,
  output logic [$clog2(MAX_SHIPS+1)-1:0]   ship_count,
  output logic                             done
);

  localparam int CELLS = NUM_DIGITS * 7;
  localparam int CW    = $clog2(CELLS);
  localparam int SCW   = $clog2(MAX_SHIPS + 1);
  localparam int DW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SDW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BDW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SCW-1:0]        MAX_SC   = SCW'(MAX_SHIPS);
  localparam logic [DW-1:0]         DIG_MAX  = DW'(NUM_DIGITS - 1);
  localparam logic [CW:0]           CELLS_W  = (CW + 1)'(CELLS);
  localparam logic [SDW-1:0]        SCAN_TOP = SDW'(SCAN_DIV - 1);
  localparam logic [BDW-1:0]        BLNK_TOP = BDW'(BLINK_DIV - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

  state_e          state;
  logic [DW-1:0]   cur_digit;
  logic [DW-1:0]   next_digit;
  logic [2:0]      cur_seg;
  logic [CW-1:0]   cur_cell;
  logic [SCW-1:0]  cpu_count;
  logic [15:0]     lfsr_q;
  logic            lfsr_unused;
  logic [CW-1:0]   cand;
  logic            cand_ok;
  dir_e            dir;
  move_t           mv;
  logic            move_req;
  logic [DW-1:0]   scan_idx;
  logic [SDW-1:0]  scan_cnt;
  logic [BDW-1:0]  blink_cnt;
  logic            blink_on;
  logic [6:0]      digit_bits;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .out (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[15:CW];
  assign cand        = lfsr_q[CW-1:0];
  assign cand_ok     = ({1'b0, cand} < CELLS_W) && !cships[cand];
  assign cur_cell    = CW'(cell_idx(32'(cur_digit), cur_seg));
  assign move_req    = btnR | btnL | btnU | btnD;

  always_comb begin
    dir = DIR_D;
    if (btnR)      dir = DIR_R;
    else if (btnL) dir = DIR_L;
    else if (btnU) dir = DIR_U;
    mv = cursor_move(cur_seg, dir);
    next_digit = cur_digit;
    case (mv.step)
      STEP_INC: next_digit = (cur_digit == DIG_MAX) ? '0 : cur_digit + 1'b1;
      STEP_DEC: next_digit = (cur_digit == '0) ? DIG_MAX : cur_digit - 1'b1;
      default:  ;
    endcase
  end

  // One action per cycle: confirm > sel > any direction button (priority folded into dir).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_PLACE;
      cur_digit  <= '0;
      cur_seg    <= SEG_A;
      pships     <= '0;
      cships     <= '0;
      ship_count <= '0;
      cpu_count  <= '0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_PLACE: begin
          if (phase) begin
            if (confirm) begin
              if (ship_count == MAX_SC) state <= ST_CPU_GEN;
            end else if (sel) begin
              if (pships[cur_cell]) begin
                pships[cur_cell] <= 1'b0;
                ship_count       <= ship_count - 1'b1;
              end else if (ship_count != MAX_SC) begin
                pships[cur_cell] <= 1'b1;
                ship_count       <= ship_count + 1'b1;
              end
            end else if (move_req) begin
              cur_seg   <= mv.seg;
              cur_digit <= next_digit;
            end
          end
        end
        ST_CPU_GEN: begin
          if (cpu_count == MAX_SC) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else if (cand_ok) begin
            cships[cand] <= 1'b1;
            cpu_count    <= cpu_count + 1'b1;
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_PLACE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt  <= SCAN_TOP;
      scan_idx  <= '0;
      blink_cnt <= BLNK_TOP;
      blink_on  <= 1'b1;
    end else begin
      if (scan_cnt == '0) begin
        scan_cnt <= SCAN_TOP;
        scan_idx <= (scan_idx == DIG_MAX) ? '0 : scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt - 1'b1;
      end
      if (blink_cnt == '0) begin
        blink_cnt <= BLNK_TOP;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    digit_bits = pships[int'(scan_idx) * 7 +: 7];
    if (state == ST_PLACE && scan_idx == cur_digit) digit_bits[cur_seg] = blink_on;
    seg = {~done, ~digit_bits};
    an  = ~(AN_ONE << scan_idx);
  end

endmodule
